// File: rtl/beep_seq_pkg.sv
// Shared types and helpers for the beep sequencer: FSM state encoding,
// lowest-set-bit arbiter function and the timer width helper.
package beep_seq_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Fixed-priority pick: index of the lowest set bit, 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [MAX_REQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (v[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic int timer_width(input int on_c, input int off_c);
    int m;
    m = (on_c > off_c) ? on_c : off_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dur_timer.sv
// Loadable down-counter that parks at zero; expired is high while count is zero.
module dur_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/beep_sequencer.sv
// Shares one buzzer among N_REQ requesters: requester i plays i+1 beeps,
// requests are latched and the lowest pending index is served next.
module beep_sequencer
  import beep_seq_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             beep,
  output logic             busy,
  output logic [N_REQ-1:0] grant,
  output logic             done
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam int RW = $clog2(N_REQ + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  state_e           state;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] eff;
  logic [N_REQ-1:0] win_onehot;
  logic [N_REQ-1:0] clear_mask;
  logic [2:0]       win_idx;
  logic [RW-1:0]    remaining;
  logic             start;
  logic             tmr_load;
  logic [TW-1:0]    tmr_load_val;
  logic             tmr_expired;

  assign eff        = pending | req;
  assign win_idx    = lowest_set(MAX_REQ'(eff));
  assign win_onehot = N_REQ'(1) << win_idx;
  assign start      = (state == IDLE) && (eff != '0);
  // Only the bit granted on this edge is removed; a simultaneous req on it is consumed.
  assign clear_mask = start ? win_onehot : '0;

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = ON_LOAD;
    case (state)
      IDLE: begin
        if (start) begin
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      ON: begin
        if (tmr_expired) begin
          tmr_load     = 1'b1;
          tmr_load_val = OFF_LOAD;
        end
      end
      OFF: begin
        if (tmr_expired) begin
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      default: begin
        tmr_load     = 1'b0;
        tmr_load_val = ON_LOAD;
      end
    endcase
  end

  dur_timer #(.W(TW)) u_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | req) & ~clear_mask;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      beep      <= 1'b0;
      busy      <= 1'b0;
      grant     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            grant     <= win_onehot;
            busy      <= 1'b1;
            beep      <= 1'b1;
            remaining <= RW'(win_idx) + RW'(1);
            state     <= ON;
          end
        end
        ON: begin
          if (tmr_expired) begin
            remaining <= remaining - RW'(1);
            beep      <= 1'b0;
            state     <= (remaining > RW'(1)) ? OFF : GAP;
          end
        end
        OFF: begin
          if (tmr_expired) begin
            beep  <= 1'b1;
            state <= ON;
          end
        end
        GAP: begin
          if (tmr_expired) begin
            busy  <= 1'b0;
            grant <= '0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer with short beep timing: table vectors, hand-written
// multi-cycle sequences and random pulses against a timeline reference model.
module tb_beep_sequencer;

  localparam int N   = 4;
  localparam int ONC = 4;
  localparam int OFC = 3;
  localparam int PER = ONC + OFC;

  logic         sys_clk;
  logic         sys_rst_n;
  logic [N-1:0] req;
  logic         beep;
  logic         busy;
  logic [N-1:0] grant;
  logic         done;

  beep_sequencer #(.N_REQ(N), .ON_CYCLES(ONC), .OFF_CYCLES(OFC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req       (req),
    .beep      (beep),
    .busy      (busy),
    .grant     (grant),
    .done      (done)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a pattern is a timeline of (i+1) periods of ONC high + OFC low,
  // positioned by the number of edges since the granting edge.
  bit       m_active;
  int       m_idx;
  int       m_t;
  logic [N-1:0] m_pend;
  bit       m_done;

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_t = 0; m_pend = '0; m_done = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    logic [N-1:0] eff;
    if (!m_active) begin
      eff    = m_pend | r;
      m_done = 0;
      if (eff != '0) begin
        for (int k = N - 1; k >= 0; k--) if (eff[k]) m_idx = k;
        m_active = 1;
        m_t      = 0;
        m_pend   = eff & ~(N'(1) << m_idx);
      end else begin
        m_pend = eff;
      end
    end else begin
      m_pend = m_pend | r;
      m_t++;
      m_done = (m_t == (m_idx + 1) * PER);
      if (m_done) m_active = 0;
    end
  endtask

  function automatic logic exp_beep();
    return m_active && ((m_t % PER) < ONC);
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return m_active ? (N'(1) << m_idx) : '0;
  endfunction

  task automatic cmp_model(input string tag);
    check({tag, ".beep"},    32'(beep),        32'(exp_beep()));
    check({tag, ".busy"},    32'(busy),        32'(m_active));
    check({tag, ".grant"},   32'(grant),       32'(exp_grant()));
    check({tag, ".done"},    32'(done),        32'(m_done));
    check({tag, ".pending"}, 32'(dut.pending), 32'(m_pend));
  endtask

  // scoreboard of grants observed at each pattern start
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  logic         prev_busy = 1'b0;

  // driver: called at a negedge, applies req for one edge, returns at the next negedge
  task automatic step(input logic [N-1:0] r);
    req = r;
    @(posedge sys_clk);
    model_edge(r);
    @(negedge sys_clk);
    req = '0;
    if (busy && !prev_busy) got_q.push_back(grant);
    prev_busy = busy;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((m_active || busy) && k < budget) begin
      step('0);
      cmp_model(tag);
      k++;
    end
    check({tag, ".drain_timeout"}, 32'(k < budget), 32'd1);
    step('0);
    cmp_model(tag);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         beep;
    logic         busy;
    logic [N-1:0] grant;
    logic         done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int busy_cnt;
    int done_at;
    logic [PER*3-1:0] pat;
    logic [PER*3-1:0] pat_exp;
    int hi_run;
    int lo_run;
    bit in_low;
    logic prev_beep;

    req       = '0;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    check("reset.beep",    32'(beep),        32'd0);
    check("reset.busy",    32'(busy),        32'd0);
    check("reset.grant",   32'(grant),       32'd0);
    check("reset.done",    32'(done),        32'd0);
    check("reset.pending", 32'(dut.pending), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) begin step('0); cmp_model("post_reset"); end

    // 1: single pulse on requester 0, table-driven
    tbl[0] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[1] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[2] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[3] = '{4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0};
    tbl[4] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0};
    tbl[5] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0};
    tbl[6] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0};
    tbl[7] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[9] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req);
      check($sformatf("t1[%0d].beep", i),  32'(beep),  32'(tbl[i].beep));
      check($sformatf("t1[%0d].busy", i),  32'(busy),  32'(tbl[i].busy));
      check($sformatf("t1[%0d].grant", i), 32'(grant), 32'(tbl[i].grant));
      check($sformatf("t1[%0d].done", i),  32'(done),  32'(tbl[i].done));
    end

    // 2: requester 2 plays three pulses, busy 21 clocks, done at E+21
    for (int c = 0; c < PER * 3; c++) pat_exp[c] = ((c % PER) < ONC);
    pat = '0;
    step(4'b0100);
    cmp_model("t2");
    pat[0]   = beep;
    busy_cnt = int'(busy);
    done_at  = -1;
    for (int k = 1; k < 40; k++) begin
      step('0);
      cmp_model("t2");
      if (k < PER * 3) pat[k] = beep;
      busy_cnt += int'(busy);
      if (done) begin done_at = k; break; end
    end
    check("t2.pattern", 32'(pat), 32'(pat_exp));
    check("t2.busy_len", 32'(busy_cnt), 32'd21);
    check("t2.done_at", 32'(done_at), 32'd21);

    // 3: two simultaneous requests; lower wins, upper follows from pending
    step(4'b1010);
    cmp_model("t3");
    check("t3.first_grant", 32'(grant), 32'b0010);
    drain("t3a", 40);
    // drain ends with one idle edge; restart from the bench side if pending was served there
    busy_cnt = int'(busy);
    check("t3.second_grant", 32'(grant), 32'b1000);
    for (int k = 0; k < 60 && busy; k++) begin
      step('0);
      cmp_model("t3b");
      busy_cnt += int'(busy);
    end
    check("t3.second_busy_len", 32'(busy_cnt), 32'd28);
    repeat (2) begin step('0); cmp_model("t3c"); end

    // 4: mid-pattern pulses on 0 and on the playing bit collapse into one replay
    got_q.delete();
    exp_q = '{4'b1000, 4'b0001, 4'b1000};
    step(4'b1000); cmp_model("t4");
    step(4'b0000); cmp_model("t4");
    step(4'b1001); cmp_model("t4");
    step(4'b0000); cmp_model("t4");
    step(4'b1000); cmp_model("t4");
    step(4'b1000); cmp_model("t4");
    step(4'b0000); cmp_model("t4");
    step(4'b1000); cmp_model("t4");
    for (int k = 0; k < 150 && (m_active || m_pend != '0 || busy); k++) begin
      step('0);
      cmp_model("t4");
    end
    repeat (3) begin step('0); cmp_model("t4.idle"); end
    check("t4.n_patterns", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("t4.grant_seq[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("t4.pending_empty", 32'(dut.pending), 32'd0);

    // 5: asynchronous reset in the middle of a pattern
    step(4'b0010); cmp_model("t5");
    step(4'b0000); cmp_model("t5");
    step(4'b0000); cmp_model("t5");
    #3 sys_rst_n = 1'b0;
    #2;
    check("t5.async_beep",    32'(beep),        32'd0);
    check("t5.async_busy",    32'(busy),        32'd0);
    check("t5.async_grant",   32'(grant),       32'd0);
    check("t5.async_done",    32'(done),        32'd0);
    check("t5.async_pending", 32'(dut.pending), 32'd0);
    model_reset();
    prev_busy = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step('0);
      busy_cnt += int'(beep);
    end
    check("t5.silent_after_reset", 32'(busy_cnt), 32'd0);
    cmp_model("t5.end");

    // 6: random single-bit pulses every cycle, then random multi-bit traffic
    hi_run = 0; lo_run = 0; in_low = 0; prev_beep = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k < 100) step(N'(1) << $urandom_range(0, N - 1));
      else if ($urandom_range(0, 3) == 0) step(N'($urandom_range(0, 15)));
      else step('0);
      cmp_model("t6");
      check("t6.grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
      if (beep) begin
        hi_run++;
        check("t6.high_run_max", 32'(hi_run <= ONC), 32'd1);
      end else begin
        hi_run = 0;
      end
      if (prev_beep && !beep && busy) begin
        in_low = 1; lo_run = 1;
      end else if (in_low && !beep && busy) begin
        lo_run++;
      end
      if (!busy) in_low = 0;
      if (beep && !prev_beep && in_low) begin
        check("t6.low_run_min", 32'(lo_run >= OFC), 32'd1);
        in_low = 0;
      end
      prev_beep = beep;
    end
    for (int k = 0; k < 200 && (m_active || m_pend != '0 || busy); k++) begin
      step('0);
      cmp_model("t6.drain");
    end
    check("t6.final_idle", 32'(busy), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
